vector_uncons_tx: RTL and testbench

Streaming byte emitter that takes a packed 128-bit byte vector and unconses it one byte per handshake, head byte first. It is the transmit/reader side for the byte-cons packer stage that builds 128-bit vectors from two 64-bit halves. It sits between the vector datapath and any byte-wide sink, and exposes a valid/ready handshake on both sides.

---
 rtl/vector_uncons_tx.sv | 141 ++++++++++++++
 tb/tb_vector_uncons_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_uncons_tx.sv
// Unconses a packed 16-byte vector onto a byte-wide valid/ready stream, head byte first.
// Optional one-entry skid for zero-bubble back-to-back vectors: define VECTOR_UNCONS_SKID_EN.
module vector_uncons_tx #(
  parameter int unsigned W_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_hi,
  input  logic [63:0] i_in_lo,
  input  logic [4:0]  i_in_len,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_out_byte,
  output logic        o_out_last
);

  localparam int unsigned VecW   = W_BYTES * 8;
  localparam logic [4:0]  MaxLen = 5'(W_BYTES);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [VecW-1:0]   r_shift, w_shift_d;
  logic [4:0]        r_cnt, w_cnt_d;

  logic [4:0]        w_in_len_clamped;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last_fire;

  assign w_in_len_clamped = (i_in_len > MaxLen) ? MaxLen : i_in_len;

`ifdef VECTOR_UNCONS_SKID_EN
  logic [VecW-1:0]   r_skid_data, w_skid_data_d;
  logic [4:0]        r_skid_len, w_skid_len_d;
  logic              r_skid_full, w_skid_full_d;

  assign o_in_ready = (r_state == StIdle) || !r_skid_full;
`else
  assign o_in_ready = (r_state == StIdle);
`endif

  assign w_in_fire   = i_in_valid && o_in_ready;
  assign w_out_fire  = o_out_valid && i_out_ready;
  assign w_last_fire = w_out_fire && (r_cnt == 5'd1);

  // Outputs come only from registered state; the byte is forced to zero outside DRAIN.
  assign o_out_valid = (r_state == StDrain);
  assign o_out_byte  = (r_state == StDrain) ? r_shift[VecW-1 -: 8] : 8'h00;
  assign o_out_last  = (r_state == StDrain) && (r_cnt == 5'd1);

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
`ifdef VECTOR_UNCONS_SKID_EN
    w_skid_data_d = r_skid_data;
    w_skid_len_d  = r_skid_len;
    w_skid_full_d = r_skid_full;
`endif
    case (r_state)
      StIdle: begin
        if (w_in_fire) begin
          w_shift_d = {i_in_hi, i_in_lo};
          w_cnt_d   = w_in_len_clamped;
          if (w_in_len_clamped != 5'd0) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (w_out_fire) begin
          w_shift_d = r_shift << 8;
          w_cnt_d   = r_cnt - 5'd1;
        end
        if (w_last_fire) begin
`ifdef VECTOR_UNCONS_SKID_EN
          // Parked vector wins; a vector accepted this very cycle bypasses the skid.
          if (r_skid_full) begin
            w_shift_d     = r_skid_data;
            w_cnt_d       = r_skid_len;
            w_skid_full_d = 1'b0;
            if (r_skid_len == 5'd0) begin
              w_state_d = StIdle;
            end
          end else if (w_in_fire) begin
            w_shift_d = {i_in_hi, i_in_lo};
            w_cnt_d   = w_in_len_clamped;
            if (w_in_len_clamped == 5'd0) begin
              w_state_d = StIdle;
            end
          end else begin
            w_state_d = StIdle;
          end
`else
          w_state_d = StIdle;
`endif
        end
`ifdef VECTOR_UNCONS_SKID_EN
        else if (w_in_fire) begin
          w_skid_data_d = {i_in_hi, i_in_lo};
          w_skid_len_d  = w_in_len_clamped;
          w_skid_full_d = 1'b1;
        end
`endif
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
    end
  end

`ifdef VECTOR_UNCONS_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_data <= '0;
      r_skid_len  <= 5'd0;
      r_skid_full <= 1'b0;
    end else begin
      r_skid_data <= w_skid_data_d;
      r_skid_len  <= w_skid_len_d;
      r_skid_full <= w_skid_full_d;
    end
  end
`endif

endmodule

// File: tb/tb_vector_uncons_tx.sv
// Scoreboard bench for vector_uncons_tx: expected {last, byte} pairs are queued when a
// vector is offered and popped by a monitor on each output handshake.
module tb_vector_uncons_tx;

  logic        clk;
  logic        rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_in_hi;
  logic [63:0] i_in_lo;
  logic [4:0]  i_in_len;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [7:0]  o_out_byte;
  logic        o_out_last;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] sb_q[$];
  logic [8:0] mon_exp;

  vector_uncons_tx dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_hi     (i_in_hi),
    .i_in_lo     (i_in_lo),
    .i_in_len    (i_in_len),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_byte  (o_out_byte),
    .o_out_last  (o_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output handshake monitor; inputs change only just after posedge, so negedge is stable.
  always @(negedge clk) begin
    if (!rst && o_out_valid && i_out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_extra: got byte %02h last %0b, expected no byte", o_out_byte,
                 o_out_last);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({o_out_last, o_out_byte} !== mon_exp) begin
          $display("FAIL sb_byte: got last=%0b byte=%02h, expected last=%0b byte=%02h",
                   o_out_last, o_out_byte, mon_exp[8], mon_exp[7:0]);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Offers a vector, queues its expected bytes, returns just after the accepting edge.
  task automatic send_vec(input logic [63:0] hi, input logic [63:0] lo, input logic [4:0] len);
    logic [127:0] v;
    int n;
    int budget;
    logic acc;
    v = {hi, lo};
    n = (len > 5'd16) ? 16 : int'(len);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({(i == n - 1), v[127 - 8 * i -: 8]});
    end
    i_in_valid = 1'b1;
    i_in_hi    = hi;
    i_in_lo    = lo;
    i_in_len   = len;
    budget     = 0;
    acc        = 1'b0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = o_in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    i_in_valid = 1'b0;
    i_in_hi    = {$urandom, $urandom};
    i_in_lo    = {$urandom, $urandom};
    i_in_len   = 5'($urandom);
    if (!acc) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  // Counts valid output cycles until the output goes idle.
  task automatic wait_drain(output int nvalid);
    int budget;
    logic v;
    nvalid = 0;
    budget = 0;
    forever begin
      @(negedge clk);
      v = o_out_valid;
      if (v) nvalid++;
      @(posedge clk);
      #1;
      budget++;
      if (!v || budget >= 400) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    n_checks++;
    if ({o_out_valid, o_out_byte, o_out_last, o_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      $display("FAIL reset_during: got v=%0b b=%02h l=%0b r=%0b, expected v=0 b=00 l=0 r=1",
               o_out_valid, o_out_byte, o_out_last, o_in_ready);
    end else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({o_out_valid, o_out_byte, o_out_last, o_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      $display("FAIL reset_after: got v=%0b b=%02h l=%0b r=%0b, expected v=0 b=00 l=0 r=1",
               o_out_valid, o_out_byte, o_out_last, o_in_ready);
    end else n_pass++;
  endtask

  task automatic test_single;
    int nv;
    i_out_ready = 1'b1;
    send_vec(64'h0102030405060708, 64'h090A0B0C0D0E0F10, 5'd16);
    wait_drain(nv);
    n_checks++;
    if (nv !== 16) $display("FAIL single_cycles: got %0d valid cycles, expected 16", nv);
    else n_pass++;
    n_checks++;
    if (sb_q.size() !== 0 || o_in_ready !== 1'b1) begin
      $display("FAIL single_end: got %0d pending ready=%0b, expected 0 pending ready=1",
               sb_q.size(), o_in_ready);
    end else n_pass++;
  endtask

  task automatic test_short_and_zero;
    int nv;
    i_out_ready = 1'b1;
    send_vec(64'h0102030405060708, 64'h090A0B0C0D0E0F10, 5'd3);
    wait_drain(nv);
    n_checks++;
    if (nv !== 3 || sb_q.size() !== 0) begin
      $display("FAIL short_len: got %0d bytes %0d pending, expected 3 bytes 0 pending",
               nv, sb_q.size());
    end else n_pass++;
    send_vec(64'h0102030405060708, 64'h090A0B0C0D0E0F10, 5'd0);
    wait_drain(nv);
    n_checks++;
    if (nv !== 0 || o_in_ready !== 1'b1) begin
      $display("FAIL zero_len: got %0d bytes ready=%0b, expected 0 bytes ready=1",
               nv, o_in_ready);
    end else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    logic       held;
    logic [8:0] held_val;
    int         bad;
    pat  = 4'b1001;
    held = 1'b0;
    held_val = 9'd0;
    bad  = 0;
    i_out_ready = 1'b0;
    send_vec(64'h1122334455667788, 64'h99AABBCCDDEEFF00, 5'd16);
    for (int c = 0; c < 200 && (sb_q.size() != 0 || o_out_valid); c++) begin
      i_out_ready = pat[3 - (c % 4)];
      @(negedge clk);
      if (held && (!o_out_valid || {o_out_last, o_out_byte} !== held_val)) begin
        bad++;
        $display("FAIL bp_hold: got v=%0b last=%0b byte=%02h, expected v=1 last=%0b byte=%02h",
                 o_out_valid, o_out_last, o_out_byte, held_val[8], held_val[7:0]);
      end
      held     = o_out_valid && !i_out_ready;
      held_val = {o_out_last, o_out_byte};
      @(posedge clk);
      #1;
    end
    i_out_ready = 1'b1;
    n_checks++;
    if (bad != 0 || sb_q.size() !== 0) begin
      $display("FAIL bp_done: got %0d hold errors %0d pending, expected 0 and 0",
               bad, sb_q.size());
    end else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c_bb;
    int c_cc;
    int exp_gap;
`ifdef VECTOR_UNCONS_SKID_EN
    exp_gap = 1;
`else
    exp_gap = 2;
`endif
    c_bb = -100;
    c_cc = -1;
    i_out_ready = 1'b1;
    fork
      begin
        send_vec(64'hAABB000000000000, 64'h0, 5'd2);
        send_vec(64'hCCDD000000000000, 64'h0, 5'd2);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          if (o_out_valid && o_out_byte == 8'hBB) c_bb = c;
          if (o_out_valid && o_out_byte == 8'hCC) c_cc = c;
          @(posedge clk);
          #1;
        end
      end
    join
    n_checks++;
    if (c_cc - c_bb !== exp_gap) begin
      $display("FAIL b2b_gap: got BB->CC spacing %0d cycles, expected %0d", c_cc - c_bb, exp_gap);
    end else n_pass++;
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL b2b_pending: got %0d, expected 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k;
    int budget;
    int nv;
    i_out_ready = 1'b1;
    send_vec(64'h0102030405060708, 64'h090A0B0C0D0E0F10, 5'd16);
    k = 0;
    budget = 0;
    while (k < 5 && budget < 100) begin
      @(negedge clk);
      if (o_out_valid && i_out_ready) k++;
      budget++;
      if (k < 5) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_out_byte !== 8'h00 || k !== 5) begin
      $display("FAIL rst_mid: got v=%0b byte=%02h after %0d bytes, expected v=0 byte=00 after 5",
               o_out_valid, o_out_byte, k);
    end else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_vec(64'h5152535455565758, 64'h0, 5'd4);
    wait_drain(nv);
    n_checks++;
    if (nv !== 4 || sb_q.size() !== 0) begin
      $display("FAIL rst_fresh: got %0d bytes %0d pending, expected 4 bytes 0 pending",
               nv, sb_q.size());
    end else n_pass++;
  endtask

  task automatic test_clamp;
    int nv;
    i_out_ready = 1'b1;
    send_vec(64'hF0E1D2C3B4A59687, 64'h78695A4B3C2D1E0F, 5'd31);
    wait_drain(nv);
    n_checks++;
    if (nv !== 16 || sb_q.size() !== 0) begin
      $display("FAIL clamp: got %0d bytes %0d pending, expected 16 bytes 0 pending",
               nv, sb_q.size());
    end else n_pass++;
  endtask

  initial begin
    rst         = 1'b1;
    i_in_valid  = 1'b0;
    i_in_hi     = 64'h0;
    i_in_lo     = 64'h0;
    i_in_len    = 5'd0;
    i_out_ready = 1'b0;
    test_reset();
    test_single();
    test_short_and_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
